// File: rtl/lfsr_block_lock.sv
// 64b/66b block synchroniser feeding the 10GBASE-R descrambler.
// Hunts for sync-header alignment by requesting gearbox bitslips, declares
// block lock after LOCK_COUNT consecutive good headers, monitors the header
// error rate in LOCK_COUNT-beat windows while locked, and forwards locked
// beats with a one-cycle registered latency.
module lfsr_block_lock #(
    parameter int DATA_WIDTH    = 64,
    parameter int HDR_WIDTH     = 2,
    parameter int LOCK_COUNT    = 64,
    parameter int INVALID_LIMIT = 16,
    parameter int SLIP_WAIT     = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [HDR_WIDTH-1:0]  hdr_in,
    input  logic                  data_in_valid,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [HDR_WIDTH-1:0]  hdr_out,
    output logic                  data_out_valid,
    output logic                  bitslip,
    output logic                  block_lock
);

    localparam int SH_W   = $clog2(LOCK_COUNT) + 1;
    localparam int INV_W  = $clog2(INVALID_LIMIT) + 1;
    localparam int WAIT_W = $clog2(SLIP_WAIT) + 1;

    localparam logic [SH_W-1:0]   SH_MAX   = SH_W'(LOCK_COUNT);
    localparam logic [INV_W-1:0]  INV_MAX  = INV_W'(INVALID_LIMIT);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(SLIP_WAIT);

    typedef enum logic [1:0] {
        ST_HUNT,
        ST_LOCKED,
        ST_SLIP
    } state_e;

    state_e                  state_q;
    logic [SH_W-1:0]         sh_cnt_q;
    logic [INV_W-1:0]        inv_cnt_q;
    logic [WAIT_W-1:0]       wait_cnt_q;
    logic [DATA_WIDTH-1:0]   data_out_q;
    logic [HDR_WIDTH-1:0]    hdr_out_q;
    logic                    data_out_valid_q;
    logic                    bitslip_q;
    logic                    block_lock_q;

    logic                    hdr_ok;
    logic [SH_W-1:0]         sh_cnt_d;
    logic [INV_W-1:0]        inv_cnt_d;
    logic [WAIT_W-1:0]       wait_cnt_d;

    // Header classification and the incremented counter values a beat would produce.
    always_comb begin
        // NOTE: every signal written here gets a value on every path, so no latch is inferred.
        hdr_ok     = (hdr_in == HDR_WIDTH'(2'b01)) || (hdr_in == HDR_WIDTH'(2'b10));
        sh_cnt_d   = sh_cnt_q + 1'b1;
        inv_cnt_d  = inv_cnt_q + {{(INV_W-1){1'b0}}, ~hdr_ok};
        wait_cnt_d = wait_cnt_q + 1'b1;
    end

    // Block-lock FSM with registered status outputs and the one-beat data pipeline.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the payload register is reset too; it is a single beat wide and the
            // descrambler must see a defined value rather than X after reset.
            state_q          <= ST_HUNT;
            sh_cnt_q         <= '0;
            inv_cnt_q        <= '0;
            wait_cnt_q       <= '0;
            data_out_q       <= '0;
            hdr_out_q        <= '0;
            data_out_valid_q <= 1'b0;
            bitslip_q        <= 1'b0;
            block_lock_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch below reads the
            // pre-edge register values and the defaults can be overridden safely.
            bitslip_q        <= 1'b0;
            data_out_valid_q <= 1'b0;

            if (data_in_valid) begin
                data_out_q <= data_in;
                hdr_out_q  <= hdr_in;
            end

            unique case (state_q)
                ST_HUNT: begin
                    if (data_in_valid) begin
                        if (!hdr_ok) begin
                            state_q    <= ST_SLIP;
                            sh_cnt_q   <= '0;
                            wait_cnt_q <= '0;
                            bitslip_q  <= 1'b1;
                        end else if (sh_cnt_d == SH_MAX) begin
                            state_q      <= ST_LOCKED;
                            sh_cnt_q     <= '0;
                            block_lock_q <= 1'b1;
                        end else begin
                            sh_cnt_q <= sh_cnt_d;
                        end
                    end
                end

                ST_LOCKED: begin
                    if (data_in_valid) begin
                        data_out_valid_q <= 1'b1;
                        // Reaching the invalid limit takes precedence over closing the window.
                        if (inv_cnt_d == INV_MAX) begin
                            state_q      <= ST_SLIP;
                            sh_cnt_q     <= '0;
                            inv_cnt_q    <= '0;
                            wait_cnt_q   <= '0;
                            bitslip_q    <= 1'b1;
                            block_lock_q <= 1'b0;
                        end else if (sh_cnt_d == SH_MAX) begin
                            sh_cnt_q  <= '0;
                            inv_cnt_q <= '0;
                        end else begin
                            sh_cnt_q  <= sh_cnt_d;
                            inv_cnt_q <= inv_cnt_d;
                        end
                    end
                end

                ST_SLIP: begin
                    // Gearbox settle time counts raw clocks; beats arriving now are dropped.
                    if (wait_cnt_d == WAIT_MAX) begin
                        state_q    <= ST_HUNT;
                        wait_cnt_q <= '0;
                        sh_cnt_q   <= '0;
                        inv_cnt_q  <= '0;
                    end else begin
                        wait_cnt_q <= wait_cnt_d;
                    end
                end

                default: begin
                    state_q <= ST_HUNT;
                end
            endcase
        end
    end

    assign data_out       = data_out_q;
    assign hdr_out        = hdr_out_q;
    assign data_out_valid = data_out_valid_q;
    assign bitslip        = bitslip_q;
    assign block_lock     = block_lock_q;

endmodule
